simon_autoplayer: RTL and testbench
===================================

Name: simon_autoplayer

Overview:
- Automated player for the Simon game core. It closes the loop on the game's display interface: it consumes `pattern_leds` and `mode_leds`, and drives the game's `pattern` and `level` inputs.
- In Input mode it supplies pseudo-random legal patterns. During Playback it records the displayed sequence. In Repeat mode it replays that sequence cycle-accurately.
- Optional single-error injection lets the bench reach the Done/lose path.
- Used for self-play regression and board demo mode.

Parameters:
- DEPTH, 64: recorded-sequence buffer entries (power of 2).
- MODE_INPUT, 3'b001: `mode_leds` code for Input mode.
- MODE_PLAY, 3'b010: `mode_leds` code for Playback mode.
- MODE_REPEAT, 3'b100: `mode_leds` code for Repeat mode.
- MODE_DONE, 3'b111: `mode_leds` code for Done mode.
- LFSR_SEED, 8'hA5: reset value of the pattern LFSR (must be non-zero).

Ports:
- clk  in  1  system clock (same clock as the game core).
- rst  in  1  synchronous, active-high reset.
- enable  in  1  autoplay enable. When low, `pattern` = 4'b0000.
- level_cfg  in  1  difficulty; latched into `level` at reset.
- inject_err  in  1  arm error injection (sampled at the entry into Repeat).
- err_index  in  $clog2(DEPTH)  Repeat-entry index at which to corrupt the output.
- mode_leds  in  3  game mode from the Simon core.
- pattern_leds  in  4  pattern displayed by the Simon core.
- pattern  out  4  pattern driven into the Simon core.
- level  out  1  level driven into the Simon core.
- rounds  out  8  completed Repeat phases (saturating).
- rec_len  out  $clog2(DEPTH)+1  entries recorded in the last Playback.
- overflow  out  1  sticky: Playback longer than DEPTH.
- game_over  out  1  high while `mode_leds` == MODE_DONE.

Behaviour:
- Reset (`rst` high at a `clk` edge) sets:
  - `prev_mode` = MODE_INPUT, `lfsr` = LFSR_SEED, `rec_idx` = 0, `rep_idx` = 0.
  - `rec_len` = 0, `rounds` = 0, `overflow` = 0, `err_armed` = 0, `level` = `level_cfg`.
  - Buffer contents are don't-care.
  - Reset mid-game abandons any recording or replay immediately.
- `level` holds its value until the next reset; changing `level_cfg` between resets has no effect.
- Buffer is a register array with asynchronous (combinational) read and synchronous write.
- `pattern` is combinational from `mode_leds`, state and buffer. There is zero latency: the value is valid in the same cycle the core samples it.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Advances one step per clock only while mode == MODE_INPUT and `enable` = 1.
- Input mode (`pattern` when `enable` = 1):
  - Level 0: one-hot, `4'b0001 << lfsr[1:0]`.
  - Level 1: `lfsr[3:0]`, or 4'b1000 if `lfsr[3:0]` == 0. It is always non-zero.
- Play mode:
  - Entry cycle (`prev_mode` != MODE_PLAY): write `buf[0]` = `pattern_leds` and set `rec_idx` = 1.
  - Each subsequent Play cycle: write `buf[rec_idx]` and increment `rec_idx`.
  - If a write is attempted with `rec_idx` == DEPTH: no write, set `overflow` = 1, hold `rec_idx`.
  - On the Play exit cycle, `rec_len` <= `rec_idx`.
  - `pattern` = 4'b0000 during Play.
- Repeat mode:
  - Entry cycle: `rep_idx` treated as 0 and `buf[0]` driven; register `rep_idx` = 1, `err_armed` <= `inject_err`.
  - Each subsequent cycle: drive `buf[rep_idx]`, then `rep_idx`++.
  - If `rep_idx` >= `rec_len`, drive 4'b0000.
- Error injection: if `err_armed` (or `inject_err` on the entry cycle) and the current index == `err_index`:
  - Drive `rotl1(buf[idx])`.
  - If that equals the original value, drive 4'b0001, or 4'b0010 if the original is 4'b0001.
- `rounds` increments (saturating at 255) on each Repeat→Input transition.
- Done mode: `pattern` = 0, `game_over` = 1, all counters hold.
- Other mode codes: `pattern` = 0, no state change except `prev_mode`.
- `prev_mode` <= `mode_leds` every cycle.
- `enable` = 0:
  - `pattern` forced to 0 and the LFSR does not advance.
  - Recording and `rounds` still track the game.

Test Plan:
1. Reset with `level_cfg`=0 and seed A5 → first Input cycle `pattern`=4'b0010 (`lfsr[1:0]`=01); `level`=0; all counters 0.
2. Play sequence 0001,0100,1000 for 3 cycles then Repeat → `rec_len`=3; Repeat cycles 0..2 drive 0001,0100,1000; cycle 3 drives 0000; after Input returns `rounds`=1.
3. `inject_err`=1, `err_index`=1, buffer {0010,1111} → Repeat drives 0010 then 0001; closed loop with the core reaches MODE_DONE and `game_over`=1.
4. `level_cfg`=1 and force `lfsr[3:0]`=0 via seed choice → Input `pattern`=1000; 256 Input cycles never produce 0000.
5. Playback of DEPTH+2 entries → `overflow`=1 (sticky), `rec_len`=DEPTH, `buf[DEPTH-1]` intact.
6. Assert `rst` mid-Repeat at `rep_idx`=2 → next cycle all outputs at reset values; `enable`=0 → `pattern`=0 in every mode.

Source files
------------

// File: rtl/simon_autoplayer.sv
// Automated player for the Simon game core: drives random legal patterns in Input mode,
// records the displayed sequence during Playback and replays it in Repeat mode.
module simon_autoplayer #(
  parameter int         DEPTH       = 64,
  parameter logic [2:0] MODE_INPUT  = 3'b001,
  parameter logic [2:0] MODE_PLAY   = 3'b010,
  parameter logic [2:0] MODE_REPEAT = 3'b100,
  parameter logic [2:0] MODE_DONE   = 3'b111,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     level_cfg,
  input  logic                     inject_err,
  input  logic [$clog2(DEPTH)-1:0] err_index,
  input  logic [2:0]               mode_leds,
  input  logic [3:0]               pattern_leds,
  output logic [3:0]               pattern,
  output logic                     level,
  output logic [7:0]               rounds,
  output logic [$clog2(DEPTH):0]   rec_len,
  output logic                     overflow,
  output logic                     game_over
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] IDX_ONE  = (AW+1)'(1);
  localparam logic [AW:0] IDX_FULL = (AW+1)'(DEPTH);

  logic [2:0]  prev_mode_q, prev_mode_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [AW:0] rec_idx_q, rec_idx_d;
  logic [AW:0] rep_idx_q, rep_idx_d;
  logic [AW:0] rec_len_q, rec_len_d;
  logic [7:0]  rounds_q, rounds_d;
  logic        overflow_q, overflow_d;
  logic        err_armed_q, err_armed_d;
  logic        level_q, level_d;

  logic [3:0]  mem_q [DEPTH];
  logic        mem_we;
  logic [AW-1:0] mem_waddr;
  logic [3:0]  mem_wdata;

  logic        play_exit;
  logic [AW:0] rep_len;
  logic [AW:0] cur_idx;
  logic        armed;
  logic [3:0]  rd_val;
  logic [3:0]  rot_val;
  logic [3:0]  rep_pat;
  logic [3:0]  in_pat;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign in_pat  = level_q ? ((lfsr_q[3:0] == 4'b0000) ? 4'b1000 : lfsr_q[3:0])
                           : (4'b0001 << lfsr_q[1:0]);

  // NOTE: every signal written here gets a default first, so no path leaves a latch behind.
  always_comb begin
    prev_mode_d = mode_leds;
    lfsr_d      = lfsr_q;
    rec_idx_d   = rec_idx_q;
    rep_idx_d   = rep_idx_q;
    rec_len_d   = rec_len_q;
    rounds_d    = rounds_q;
    overflow_d  = overflow_q;
    err_armed_d = err_armed_q;
    level_d     = level_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = pattern_leds;
    cur_idx     = rep_idx_q;
    armed       = err_armed_q;
    rd_val      = 4'b0000;
    rot_val     = 4'b0000;
    rep_pat     = 4'b0000;
    pattern     = 4'b0000;

    // The recorded length is registered on the Play exit cycle, which is also the
    // Repeat entry cycle, so replay bypasses the register to stay cycle-accurate.
    play_exit = (prev_mode_q == MODE_PLAY) && (mode_leds != MODE_PLAY);
    rep_len   = play_exit ? rec_idx_q : rec_len_q;
    if (play_exit) rec_len_d = rec_idx_q;

    if (mode_leds == MODE_INPUT) begin
      if (enable) begin
        lfsr_d  = {lfsr_q[6:0], lfsr_fb};
        pattern = in_pat;
      end
      if (prev_mode_q == MODE_REPEAT && rounds_q != 8'hFF) rounds_d = rounds_q + 8'd1;
    end else if (mode_leds == MODE_PLAY) begin
      if (prev_mode_q != MODE_PLAY) begin
        mem_we    = 1'b1;
        mem_waddr = '0;
        rec_idx_d = IDX_ONE;
      end else if (rec_idx_q == IDX_FULL) begin
        overflow_d = 1'b1;
      end else begin
        mem_we    = 1'b1;
        mem_waddr = rec_idx_q[AW-1:0];
        rec_idx_d = rec_idx_q + IDX_ONE;
      end
    end else if (mode_leds == MODE_REPEAT) begin
      if (prev_mode_q != MODE_REPEAT) begin
        cur_idx     = '0;
        armed       = inject_err;
        rep_idx_d   = IDX_ONE;
        err_armed_d = inject_err;
      end else if (rep_idx_q != IDX_FULL) begin
        rep_idx_d = rep_idx_q + IDX_ONE;
      end
      rd_val  = mem_q[cur_idx[AW-1:0]];
      rot_val = {rd_val[2:0], rd_val[3]};
      if (cur_idx >= rep_len) begin
        rep_pat = 4'b0000;
      end else if (armed && cur_idx == {1'b0, err_index}) begin
        // Rotation is a no-op on 0000/1111; fall back to a fixed value that differs.
        if (rot_val == rd_val) rep_pat = (rd_val == 4'b0001) ? 4'b0010 : 4'b0001;
        else                   rep_pat = rot_val;
      end else begin
        rep_pat = rd_val;
      end
      if (enable) pattern = rep_pat;
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_mode_q <= MODE_INPUT;
      lfsr_q      <= LFSR_SEED;
      rec_idx_q   <= '0;
      rep_idx_q   <= '0;
      rec_len_q   <= '0;
      rounds_q    <= '0;
      overflow_q  <= 1'b0;
      err_armed_q <= 1'b0;
      level_q     <= level_cfg;
    end else begin
      prev_mode_q <= prev_mode_d;
      lfsr_q      <= lfsr_d;
      rec_idx_q   <= rec_idx_d;
      rep_idx_q   <= rep_idx_d;
      rec_len_q   <= rec_len_d;
      rounds_q    <= rounds_d;
      overflow_q  <= overflow_d;
      err_armed_q <= err_armed_d;
      level_q     <= level_d;
    end
  end

  // NOTE: the sequence buffer has no reset; entries are only read below the recorded length.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign level     = level_q;
  assign rounds    = rounds_q;
  assign rec_len   = rec_len_q;
  assign overflow  = overflow_q;
  assign game_over = (mode_leds == MODE_DONE);

endmodule

// File: tb/tb_simon_autoplayer.sv
// Self-checking bench for simon_autoplayer: a queue-based reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_simon_autoplayer;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam logic [2:0] M_IN = 3'b001, M_PL = 3'b010, M_RP = 3'b100, M_DN = 3'b111;

  logic          clk = 1'b0;
  logic          rst, enable, level_cfg, inject_err;
  logic [AW-1:0] err_index;
  logic [2:0]    mode_leds;
  logic [3:0]    pattern_leds;
  logic [3:0]    pattern;
  logic          level;
  logic [7:0]    rounds;
  logic [AW:0]   rec_len;
  logic          overflow;
  logic          game_over;

  simon_autoplayer dut (
    .clk(clk), .rst(rst), .enable(enable), .level_cfg(level_cfg),
    .inject_err(inject_err), .err_index(err_index), .mode_leds(mode_leds),
    .pattern_leds(pattern_leds), .pattern(pattern), .level(level), .rounds(rounds),
    .rec_len(rec_len), .overflow(overflow), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model ------------------------------------------------------------
  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic logic [3:0] input_pat(input logic [7:0] v, input bit lvl);
    if (lvl) return (v[3:0] == 4'd0) ? 4'b1000 : v[3:0];
    return 4'b0001 << v[1:0];
  endfunction

  function automatic logic [3:0] corrupt(input logic [3:0] v);
    logic [3:0] r;
    r = {v[2:0], v[3]};
    if (r == v) return (v == 4'b0001) ? 4'b0010 : 4'b0001;
    return r;
  endfunction

  bit         m_valid = 0;
  logic [7:0] m_lfsr;
  logic [2:0] m_prev;
  logic [3:0] m_seq[$];
  int         m_len, m_len_out, m_rep_n, m_rounds;
  bit         m_armed, m_ovf, m_level;
  logic [3:0] exp_pat;
  int         pos;
  bit         armed;

  always @(negedge clk) begin
    if (rst) begin
      m_valid = 1; m_lfsr = 8'hA5; m_prev = M_IN; m_seq.delete();
      m_len = 0; m_len_out = 0; m_rep_n = 0; m_rounds = 0;
      m_armed = 0; m_ovf = 0; m_level = level_cfg;
    end else if (m_valid) begin
      if (m_prev == M_PL && mode_leds != M_PL) m_len = m_seq.size();
      exp_pat = 4'b0000;
      if (mode_leds == M_IN) begin
        exp_pat = input_pat(m_lfsr, m_level);
      end else if (mode_leds == M_RP) begin
        pos   = (m_prev != M_RP) ? 0 : m_rep_n;
        armed = (m_prev != M_RP) ? inject_err : m_armed;
        if (pos < m_len) begin
          exp_pat = m_seq[pos];
          if (armed && pos == int'(err_index)) exp_pat = corrupt(exp_pat);
        end
      end
      if (!enable) exp_pat = 4'b0000;
      check("model_pattern",   pattern,   exp_pat);
      check("model_level",     level,     m_level);
      check("model_rounds",    rounds,    m_rounds);
      check("model_rec_len",   rec_len,   m_len_out);
      check("model_overflow",  overflow,  m_ovf);
      check("model_game_over", game_over, mode_leds == M_DN);
      if (mode_leds == M_IN) begin
        if (enable) m_lfsr = lfsr_step(m_lfsr);
        if (m_prev == M_RP && m_rounds < 255) m_rounds++;
      end else if (mode_leds == M_PL) begin
        if (m_prev != M_PL) begin
          m_seq.delete();
          m_seq.push_back(pattern_leds);
        end else if (m_seq.size() < DEPTH) m_seq.push_back(pattern_leds);
        else m_ovf = 1;
      end else if (mode_leds == M_RP) begin
        if (m_prev != M_RP) begin
          m_rep_n = 1; m_armed = inject_err;
        end else m_rep_n++;
      end
      m_len_out = m_len;
      m_prev    = mode_leds;
    end
  end

  // Directed stimulus ----------------------------------------------------------
  task automatic step(input logic [2:0] m, input logic [3:0] p);
    mode_leds = m; pattern_leds = p; #2;
  endtask

  task automatic adv();
    @(posedge clk); #1;
  endtask

  int         zeros, n1000;
  logic [2:0] next_mode;
  logic [2:0] odd_modes [5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; enable = 1; level_cfg = 0; inject_err = 0; err_index = '0;
    mode_leds = M_IN; pattern_leds = '0;
    repeat (2) @(posedge clk);
    #1; rst = 0;

    // Reset state and first LFSR patterns (A5 -> 4A -> 95)
    step(M_IN, 0);
    check("t1_pattern0", pattern, 4'b0010);
    check("t1_level", level, 1'b0);
    check("t1_rounds", rounds, 8'd0);
    check("t1_rec_len", rec_len, 7'd0);
    check("t1_overflow", overflow, 1'b0);
    check("t1_game_over", game_over, 1'b0);
    adv(); step(M_IN, 0); check("t1_pattern1", pattern, 4'b0100);
    adv(); step(M_IN, 0); check("t1_pattern2", pattern, 4'b0010);
    adv();

    // Record three entries, replay them
    step(M_PL, 4'b0001); check("t2_play_pat", pattern, 4'b0000); adv();
    step(M_PL, 4'b0100); adv();
    step(M_PL, 4'b1000); adv();
    step(M_RP, 0); check("t2_rep0", pattern, 4'b0001); adv();
    step(M_RP, 0); check("t2_rep1", pattern, 4'b0100); check("t2_rec_len", rec_len, 7'd3); adv();
    step(M_RP, 0); check("t2_rep2", pattern, 4'b1000); adv();
    step(M_RP, 0); check("t2_rep3", pattern, 4'b0000); adv();
    step(M_IN, 0); adv();
    step(M_IN, 0); check("t2_rounds", rounds, 8'd1); adv();

    // Error injection drives the game to Done
    step(M_PL, 4'b0010); adv();
    step(M_PL, 4'b1111); adv();
    inject_err = 1; err_index = 6'd1;
    step(M_RP, 0); check("t3_rep0", pattern, 4'b0010); adv();
    inject_err = 0;
    step(M_RP, 0); check("t3_rep1", pattern, 4'b0001);
    next_mode = (pattern === 4'b1111) ? M_IN : M_DN;
    adv();
    step(next_mode, 0); check("t3_game_over", game_over, 1'b1); check("t3_done_pat", pattern, 4'b0000); adv();
    step(M_DN, 0); check("t3_rounds_hold", rounds, 8'd1); adv();
    step(M_IN, 0); adv();

    // Level 1: never zero; nibble 0 maps to 1000
    rst = 1; level_cfg = 1; adv();
    rst = 0; level_cfg = 0;
    zeros = 0; n1000 = 0;
    for (int i = 0; i < 256; i++) begin
      step(M_IN, 0);
      if (i == 0) check("t4_first_pat", pattern, 4'b0101);
      if (pattern == 4'b0000) zeros++;
      if (pattern == 4'b1000) n1000++;
      adv();
    end
    check("t4_level_latched", level, 1'b1);
    check("t4_zero_count", zeros, 0);
    check("t4_1000_count", n1000, 31);

    // Overflow: DEPTH+2 Play cycles
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(M_PL, (i < DEPTH) ? 4'((i % 15) + 1) : 4'hF);
      adv();
    end
    check("t5_overflow", overflow, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) begin
      step(M_RP, 0);
      if (i == 1) check("t5_rec_len", rec_len, 7'd64);
      if (i == DEPTH - 1) check("t5_last_entry", pattern, 4'b0100);
      if (i == DEPTH) check("t5_past_end", pattern, 4'b0000);
      adv();
    end
    step(M_IN, 0); adv();
    check("t5_overflow_sticky", overflow, 1'b1);

    // Reset mid-Repeat, then enable low in every mode
    step(M_PL, 4'b0001); adv();
    step(M_PL, 4'b0010); adv();
    step(M_PL, 4'b0100); adv();
    step(M_RP, 0); adv();
    step(M_RP, 0); adv();
    rst = 1; step(M_RP, 0); adv();
    rst = 0; enable = 0;
    step(M_IN, 0);
    check("t6_pattern", pattern, 4'b0000);
    check("t6_rounds", rounds, 8'd0);
    check("t6_rec_len", rec_len, 7'd0);
    check("t6_overflow", overflow, 1'b0);
    check("t6_level", level, 1'b0);
    adv();
    odd_modes[0] = M_PL; odd_modes[1] = M_RP; odd_modes[2] = M_DN;
    odd_modes[3] = 3'b011; odd_modes[4] = M_IN;
    for (int i = 0; i < 5; i++) begin
      step(odd_modes[i], 4'b1010);
      check("t6_disabled_pat", pattern, 4'b0000);
      adv();
    end
    enable = 1;
    step(M_IN, 0); check("t6_lfsr_held", pattern, 4'b0010); adv();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
